// File: rtl/spike_packet_receiver.sv
// spike_packet_receiver
//   Receiving end of the spike packet link. Incoming 24-bit packets
//   {source[23:12], destination[11:0]} are buffered in a small FIFO. Each
//   packet is popped into a holding register. Its destination is compared
//   against the local lane address table. On a match, the source address is
//   delivered to that lane as a one-cycle strobe.
//
// Ports
//   CLK                             in   clock, posedge
//   RESET                           in   synchronous reset, active-high
//   clear                           in   timestep clear, suppresses delivery
//   neuron_addresses_initialization in   lane address table, lane 0 in the MSBs
//   pkt_valid / pkt_data            in   ingress packet handshake
//   pkt_ready                       out  FIFO can accept (low in reset or when full)
//   src_addr_out                    out  source address of the last strobed packet
//   lane_valid                      out  one-hot delivery strobe, bit i = lane i
//   fifo_count                      out  occupied FIFO entries
//   drop_count                      out  saturating count of unmatched packets
module spike_packet_receiver #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          clear,
  input  logic [NUM_NEURONS*ADDR_W-1:0] neuron_addresses_initialization,
  input  logic                          pkt_valid,
  input  logic [2*ADDR_W-1:0]           pkt_data,
  output logic                          pkt_ready,
  output logic [ADDR_W-1:0]             src_addr_out,
  output logic [NUM_NEURONS-1:0]        lane_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PKT_W = 2 * ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MATCH    = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_e;

  logic [PKT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   full_s, empty_s, push_s, pop_s;

  state_e                 state_q, state_d;
  logic [PKT_W-1:0]       pkt_q, pkt_d;
  logic [NUM_NEURONS-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0]      src_q, src_d;
  logic [15:0]            drop_q, drop_d;

  logic [NUM_NEURONS-1:0] match_onehot_s;
  logic                   match_any_s;

  assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_s   = (count_q == {CNT_W{1'b0}});
  // Ready ignores a same-cycle pop so the full condition never depends on the FSM.
  assign pkt_ready = !RESET && !full_s;
  assign push_s    = pkt_valid && pkt_ready;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= pkt_data;
    end
  end

  // FIFO pointers and occupancy; pointers are log2(depth) wide and wrap naturally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Destination decode; scanning from the top down lets the lowest matching lane win.
  always_comb begin
    match_onehot_s = '0;
    match_any_s    = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pkt_q[ADDR_W-1:0] ==
          neuron_addresses_initialization[(NUM_NEURONS-i)*ADDR_W-1 -: ADDR_W]) begin
        match_onehot_s    = '0;
        match_onehot_s[i] = 1'b1;
        match_any_s       = 1'b1;
      end
    end
  end

  // Delivery FSM next-state and output logic.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    lane_d  = '0;
    src_d   = src_q;
    drop_d  = drop_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s && !clear) begin
          pop_s   = 1'b1;
          pkt_d   = mem_q[rd_ptr_q];
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        if (clear) begin
          // Hold the packet; it is delivered once clear drops.
          state_d = S_WAIT_CLR;
        end else begin
          if (match_any_s) begin
            lane_d = match_onehot_s;
            src_d  = pkt_q[PKT_W-1:ADDR_W];
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
          // Back-to-back pop keeps throughput at one packet per cycle.
          if (!empty_s) begin
            pop_s = 1'b1;
            pkt_d = mem_q[rd_ptr_q];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_CLR: begin
        if (!clear) begin
          state_d = S_MATCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pkt_q   <= {PKT_W{1'b0}};
      lane_q  <= {NUM_NEURONS{1'b0}};
      src_q   <= {ADDR_W{1'b0}};
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      lane_q  <= lane_d;
      src_q   <= src_d;
      drop_q  <= drop_d;
    end
  end

  assign lane_valid   = lane_q;
  assign src_addr_out = src_q;
  assign fifo_count   = count_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Testbench for spike_packet_receiver: directed scenarios plus a randomized
// run checked against an in-order delivery model (queue of accepted packets,
// first-matching-lane lookup, drop accounting).
module tb_spike_packet_receiver;

  localparam int N = 10;
  localparam int W = 12;
  localparam int D = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           clear;
  logic [N*W-1:0] addr_init;
  logic           pkt_valid;
  logic [2*W-1:0] pkt_data;
  logic           pkt_ready;
  logic [W-1:0]   src_addr_out;
  logic [N-1:0]   lane_valid;
  logic [3:0]     fifo_count;
  logic [15:0]    drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]   lane_addr [N];
  logic [2*W-1:0] exp_q [$];
  int             exp_drop;
  logic           clr_at_edge;

  spike_packet_receiver #(.NUM_NEURONS(N), .ADDR_W(W), .FIFO_DEPTH(D)) dut (
    .CLK                             (CLK),
    .RESET                           (RESET),
    .clear                           (clear),
    .neuron_addresses_initialization (addr_init),
    .pkt_valid                       (pkt_valid),
    .pkt_data                        (pkt_data),
    .pkt_ready                       (pkt_ready),
    .src_addr_out                    (src_addr_out),
    .lane_valid                      (lane_valid),
    .fifo_count                      (fifo_count),
    .drop_count                      (drop_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic pack_addrs();
    for (int i = 0; i < N; i++) addr_init[(N-i)*W-1 -: W] = lane_addr[i];
  endtask

  task automatic default_addrs();
    for (int i = 0; i < N; i++) lane_addr[i] = W'(i);
    pack_addrs();
  endtask

  // Model lookup: first lane (lowest index) whose address equals dest.
  function automatic logic [N-1:0] ref_lane(input logic [W-1:0] dest);
    logic [N-1:0] r;
    logic found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && lane_addr[i] == dest) begin
        r[i] = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Advance one clock: record accepted packet and clear value at the edge.
  task automatic cycle();
    #1;
    if (pkt_valid && pkt_ready) exp_q.push_back(pkt_data);
    clr_at_edge = clear;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; clear = 1'b0; pkt_valid = 1'b1; pkt_data = {12'd5, 12'd3};
    cycle(); cycle();
    n_checks++;
    if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", pkt_ready); end
    RESET = 1'b0; pkt_valid = 1'b0;
    #1;
    n_checks++;
    if (pkt_ready !== 1'b1 || lane_valid !== 10'd0 || fifo_count !== 4'd0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b lv=%b cnt=%0d drop=%0d want 1,0,0,0",
               pkt_ready, lane_valid, fifo_count, drop_count);
    end
    cycle(); cycle();
    n_checks++;
    if (fifo_count !== 4'd0 || lane_valid !== 10'd0) begin
      n_fail++; $display("FAIL reset_no_push: got cnt=%0d lv=%b want 0,0", fifo_count, lane_valid);
    end
  endtask

  task automatic test_latency();
    pkt_valid = 1'b1; pkt_data = {12'd5, 12'd3};
    cycle();
    pkt_valid = 1'b0;
    n_checks++;
    if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL lat_n: got %b want 0", lane_valid); end
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL lat_n1: got %b want 0", lane_valid); end
    cycle();
    n_checks++;
    if (lane_valid !== 10'b0000001000 || src_addr_out !== 12'd5) begin
      n_fail++; $display("FAIL lat_n2: got lv=%b src=%0d want 0000001000,5", lane_valid, src_addr_out);
    end
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0 || src_addr_out !== 12'd5) begin
      n_fail++; $display("FAIL lat_pulse: got lv=%b src=%0d want 0,5", lane_valid, src_addr_out);
    end
  endtask

  task automatic test_drop();
    pkt_valid = 1'b1; pkt_data = {12'd1, 12'hFFB};
    cycle();
    pkt_data = {12'd7, 12'd9};
    cycle();
    pkt_valid = 1'b0;
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL drop: got lv=%b drop=%0d want 0,1", lane_valid, drop_count);
    end
    cycle();
    n_checks++;
    if (lane_valid !== 10'b1000000000 || src_addr_out !== 12'd7) begin
      n_fail++; $display("FAIL drop_nobubble: got lv=%b src=%0d want 1000000000,7", lane_valid, src_addr_out);
    end
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL drop_pulse: got %b want 0", lane_valid); end
  endtask

  task automatic test_clear_fill();
    logic [N-1:0] one;
    one = 10'd1;
    clear = 1'b1; pkt_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      pkt_data = {12'(20 + k), 12'(k)};
      #1;
      if (k == 8) begin
        n_checks++;
        if (pkt_ready !== 1'b0 || fifo_count !== 4'd8) begin
          n_fail++; $display("FAIL fill_full: got ready=%b cnt=%0d want 0,8", pkt_ready, fifo_count);
        end
      end
      cycle();
      n_checks++;
      if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL fill_strobe k=%0d: got %b want 0", k, lane_valid); end
    end
    pkt_valid = 1'b0; clear = 1'b0;
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL fill_pop: got %b want 0", lane_valid); end
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_checks++;
      if (lane_valid !== (one << k) || src_addr_out !== 12'(20 + k)) begin
        n_fail++; $display("FAIL fill_drain k=%0d: got lv=%b src=%0d want %b,%0d",
                           k, lane_valid, src_addr_out, one << k, 20 + k);
      end
    end
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL fill_end: got lv=%b cnt=%0d want 0,0", lane_valid, fifo_count);
    end
  endtask

  task automatic test_clear_match();
    pkt_valid = 1'b1; pkt_data = {12'd33, 12'd6};
    cycle();
    pkt_valid = 1'b0;
    cycle();
    clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL clrmatch_hold k=%0d: got %b want 0", k, lane_valid); end
    end
    clear = 1'b0;
    cycle();
    n_checks++;
    if (lane_valid !== 10'd0) begin n_fail++; $display("FAIL clrmatch_resume: got %b want 0", lane_valid); end
    cycle();
    n_checks++;
    if (lane_valid !== 10'b0001000000 || src_addr_out !== 12'd33) begin
      n_fail++; $display("FAIL clrmatch_strobe: got lv=%b src=%0d want 0001000000,33", lane_valid, src_addr_out);
    end
  endtask

  task automatic test_duplicate();
    lane_addr[2] = 12'd4; lane_addr[7] = 12'd4; lane_addr[4] = 12'd100;
    pack_addrs();
    pkt_valid = 1'b1; pkt_data = {12'd44, 12'd4};
    cycle();
    pkt_valid = 1'b0;
    cycle(); cycle();
    n_checks++;
    if (lane_valid !== 10'b0000000100 || src_addr_out !== 12'd44) begin
      n_fail++; $display("FAIL duplicate: got lv=%b src=%0d want 0000000100,44", lane_valid, src_addr_out);
    end
    cycle();
    default_addrs();
  endtask

  task automatic test_reset_mid();
    clear = 1'b1; pkt_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pkt_data = {12'(50 + k), 12'(k)};
      cycle();
    end
    pkt_valid = 1'b0; clear = 1'b0;
    cycle();
    n_checks++;
    if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL rstmid_queued: got %0d want 4", fifo_count); end
    RESET = 1'b1;
    cycle();
    n_checks++;
    if (fifo_count !== 4'd0 || lane_valid !== 10'd0) begin
      n_fail++; $display("FAIL rstmid_reset: got cnt=%0d lv=%b want 0,0", fifo_count, lane_valid);
    end
    RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (fifo_count !== 4'd0 || lane_valid !== 10'd0) begin
        n_fail++; $display("FAIL rstmid_after k=%0d: got cnt=%0d lv=%b want 0,0", k, fifo_count, lane_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] p;
    logic [N-1:0]   e;
    logic           found;
    RESET = 1'b1; pkt_valid = 1'b0; clear = 1'b0;
    cycle();
    RESET = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    for (int i = 0; i < N; i++) lane_addr[i] = W'($urandom_range(0, 15));
    pack_addrs();
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 600) begin
        pkt_valid = ($urandom_range(0, 9) < 7);
        clear     = ($urandom_range(0, 9) < 2);
        pkt_data  = {12'($urandom), 12'($urandom_range(0, 15))};
      end else begin
        pkt_valid = 1'b0;
        clear     = 1'b0;
      end
      cycle();
      if (lane_valid !== 10'd0) begin
        n_checks++;
        if (clr_at_edge) begin
          n_fail++; $display("FAIL rand_clear_strobe cyc=%0d: got lv=%b want 0", cyc, lane_valid);
        end
        found = 1'b0;
        e = '0;
        p = '0;
        while (exp_q.size() > 0 && !found) begin
          p = exp_q.pop_front();
          e = ref_lane(p[W-1:0]);
          if (e == '0) exp_drop++;
          else found = 1'b1;
        end
        n_checks++;
        if (!found || lane_valid !== e || src_addr_out !== p[2*W-1:W]) begin
          n_fail++; $display("FAIL rand_delivery cyc=%0d: got lv=%b src=%0d want lv=%b src=%0d (model has=%b)",
                             cyc, lane_valid, src_addr_out, e, p[2*W-1:W], found);
        end
      end
    end
    n_checks++;
    if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rand_drain: got cnt=%0d want 0", fifo_count); end
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      n_checks++;
      if (ref_lane(p[W-1:0]) != '0) begin
        n_fail++; $display("FAIL rand_missing: got no strobe want delivery of src=%0d dst=%0d", p[2*W-1:W], p[W-1:0]);
      end else begin
        exp_drop++;
      end
    end
    n_checks++;
    if (drop_count !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL rand_drops: got %0d want %0d", drop_count, exp_drop);
    end
  endtask

  initial begin
    RESET = 1'b1; clear = 1'b0; pkt_valid = 1'b0; pkt_data = '0; clr_at_edge = 1'b0;
    exp_drop = 0;
    default_addrs();
    @(posedge CLK); #1;
    test_reset();
    test_latency();
    test_drop();
    cycle(); cycle();
    test_clear_fill();
    test_clear_match();
    cycle(); cycle();
    test_duplicate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
